// File: rtl/cv32e40p_tmr_err_monitor.sv
// cv32e40p_tmr_err_monitor: per-source TMR voter error counters, sticky flags,
// persistent-fault latch and a two-cycle counter read port.
module cv32e40p_tmr_err_monitor #(
    parameter int NUM_SRC    = 9,
    parameter int CNT_W      = 8,
    parameter int PERSIST_TH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] err_i,
    input  logic               valid_i,
    input  logic               clear_i,
    input  logic               rd_req_i,
    input  logic [3:0]         rd_idx_i,
    output logic               rd_ack_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_SRC-1:0] sticky_o,
    output logic               persist_fault_o,
    output logic [3:0]         fault_idx_o,
    output logic               irq_o
);
    localparam logic [3:0]       TH   = 4'(PERSIST_TH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic {MON, FAULT} p_state_t;
    typedef enum logic {R_IDLE, R_ACK} r_state_t;

    p_state_t           p_state, p_nxt;
    r_state_t           r_state, r_nxt;
    logic [CNT_W-1:0]   cnt [NUM_SRC];
    logic [3:0]         run [NUM_SRC];
    logic [3:0]         run_nxt [NUM_SRC];
    logic [NUM_SRC-1:0] qual, hit;
    logic [3:0]         lo, idx_nxt;
    logic [CNT_W-1:0]   rd_q;

    assign qual = err_i & {NUM_SRC{valid_i}};

    // Descending scan leaves the lowest reaching index in lo.
    always_comb begin
        hit = '0;
        lo  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            run_nxt[k] = !valid_i ? run[k] : !err_i[k] ? 4'd0 : (run[k] == TH) ? TH : run[k] + 4'd1;
            hit[k]     = run_nxt[k] == TH;
            if (hit[k]) lo = 4'(k);
        end
    end

    always_comb begin
        p_nxt   = p_state;
        idx_nxt = fault_idx_o;
        if (clear_i) begin
            p_nxt   = MON;
            idx_nxt = '0;
        end else if (p_state == MON && |hit) begin
            p_nxt   = FAULT;
            idx_nxt = lo;
        end
    end

    always_comb r_nxt = (r_state == R_IDLE && rd_req_i) ? R_ACK : R_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state     <= MON;
            r_state     <= R_IDLE;
            fault_idx_o <= '0;
            irq_o       <= 1'b0;
            sticky_o    <= '0;
            rd_q        <= '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt[k] <= '0;
                run[k] <= '0;
            end
        end else begin
            p_state     <= p_nxt;
            r_state     <= r_nxt;
            fault_idx_o <= idx_nxt;
            irq_o       <= !clear_i && (|sticky_o || |qual || p_nxt == FAULT);
            sticky_o    <= clear_i ? '0 : sticky_o | qual;
            // Capture uses the pre-update counter, so a same-cycle clear returns the old value.
            if (r_state == R_IDLE && rd_req_i)
                rd_q <= ({28'b0, rd_idx_i} < NUM_SRC) ? cnt[rd_idx_i] : '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt[k] <= clear_i ? '0 : (qual[k] && cnt[k] != CMAX) ? cnt[k] + 1'b1 : cnt[k];
                run[k] <= clear_i ? '0 : run_nxt[k];
            end
        end
    end

    assign persist_fault_o = p_state == FAULT;
    assign rd_ack_o        = r_state == R_ACK;
    assign rd_data_o       = rd_ack_o ? rd_q : '0;
endmodule

// File: tb/tb_cv32e40p_tmr_err_monitor.sv
// tb_cv32e40p_tmr_err_monitor: directed scenario tests for the TMR error monitor.
module tb_cv32e40p_tmr_err_monitor;
    logic       clk = 0;
    logic       rst, valid_i, clear_i, rd_req_i;
    logic [8:0] err_i;
    logic [3:0] rd_idx_i;
    logic       rd_ack_o, persist_fault_o, irq_o;
    logic [7:0] rd_data_o;
    logic [8:0] sticky_o;
    logic [3:0] fault_idx_o;
    int         tests = 0;
    int         fails = 0;

    cv32e40p_tmr_err_monitor dut (
        .clk(clk), .rst(rst), .err_i(err_i), .valid_i(valid_i), .clear_i(clear_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_ack_o(rd_ack_o), .rd_data_o(rd_data_o),
        .sticky_o(sticky_o), .persist_fault_o(persist_fault_o), .fault_idx_o(fault_idx_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; valid_i = 0; clear_i = 0; rd_req_i = 0; err_i = '0; rd_idx_i = '0;
        tick();
        rst = 0;
    endtask

    task automatic errs(input logic [8:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            err_i = e; valid_i = 1;
            tick();
        end
        err_i = '0; valid_i = 0;
    endtask

    task automatic start_read(input logic [3:0] idx);
        rd_req_i = 1; rd_idx_i = idx;
        tick();
        rd_req_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (rd_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %b exp 0", rd_ack_o); end
        tests++; if (rd_data_o !== 8'd0) begin fails++; $display("FAIL reset_data got %0d exp 0", rd_data_o); end
        tests++; if (persist_fault_o !== 1'b0) begin fails++; $display("FAIL reset_fault got %b exp 0", persist_fault_o); end
        tests++; if (fault_idx_o !== 4'd0) begin fails++; $display("FAIL reset_idx got %0d exp 0", fault_idx_o); end
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", irq_o); end
        tests++; if (sticky_o !== 9'h000) begin fails++; $display("FAIL reset_sticky got %h exp 000", sticky_o); end
    endtask

    task automatic test_count();
        do_reset();
        errs(9'h010, 3);
        tests++; if (sticky_o !== 9'h010) begin fails++; $display("FAIL count_sticky got %h exp 010", sticky_o); end
        tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL count_irq got %b exp 1", irq_o); end
        tests++; if (persist_fault_o !== 1'b0) begin fails++; $display("FAIL count_fault got %b exp 0", persist_fault_o); end
        start_read(4'd4);
        tests++; if (rd_ack_o !== 1'b1) begin fails++; $display("FAIL count_ack got %b exp 1", rd_ack_o); end
        tests++; if (rd_data_o !== 8'd3) begin fails++; $display("FAIL count_data got %0d exp 3", rd_data_o); end
        tick();
        tests++; if (rd_ack_o !== 1'b0 || rd_data_o !== 8'd0) begin fails++; $display("FAIL count_pulse got ack %b data %0d exp 0 0", rd_ack_o, rd_data_o); end
        start_read(4'd5);
        tests++; if (rd_data_o !== 8'd0) begin fails++; $display("FAIL count_other got %0d exp 0", rd_data_o); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        errs(9'h001, 300);
        start_read(4'd0);
        tests++; if (rd_data_o !== 8'd255) begin fails++; $display("FAIL sat_data got %0d exp 255", rd_data_o); end
        tests++; if (persist_fault_o !== 1'b1 || fault_idx_o !== 4'd0) begin fails++; $display("FAIL sat_fault got %b/%0d exp 1/0", persist_fault_o, fault_idx_o); end
        tick();
    endtask

    task automatic test_persist();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tests++; if (persist_fault_o !== 1'b0) begin fails++; $display("FAIL persist_early%0d got %b exp 0", i, persist_fault_o); end
            errs(9'h004, 1);
            err_i = 9'h004; valid_i = 0;
            tick();
            err_i = '0;
        end
        tests++; if (persist_fault_o !== 1'b1) begin fails++; $display("FAIL persist_fault got %b exp 1", persist_fault_o); end
        tests++; if (fault_idx_o !== 4'd2) begin fails++; $display("FAIL persist_idx got %0d exp 2", fault_idx_o); end
    endtask

    task automatic test_no_persist();
        logic [8:0] pat [4];
        pat = '{9'h004, 9'h004, 9'h000, 9'h004};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            errs(pat[i], 1);
            tick();
        end
        tests++; if (persist_fault_o !== 1'b0) begin fails++; $display("FAIL nopersist_fault got %b exp 0", persist_fault_o); end
        tests++; if (sticky_o !== 9'h004 || irq_o !== 1'b1) begin fails++; $display("FAIL nopersist_sticky got %h/%b exp 004/1", sticky_o, irq_o); end
    endtask

    task automatic test_multi();
        do_reset();
        errs(9'h0A0, 4);
        tests++; if (persist_fault_o !== 1'b1 || fault_idx_o !== 4'd5) begin fails++; $display("FAIL multi_idx got %b/%0d exp 1/5", persist_fault_o, fault_idx_o); end
        start_read(4'd7);
        tests++; if (rd_data_o !== 8'd4) begin fails++; $display("FAIL multi_cnt7 got %0d exp 4", rd_data_o); end
        tick();
        errs(9'h002, 5);
        tests++; if (fault_idx_o !== 4'd5) begin fails++; $display("FAIL multi_hold got %0d exp 5", fault_idx_o); end
        clear_i = 1;
        tick();
        clear_i = 0;
        tests++; if (persist_fault_o !== 1'b0 || irq_o !== 1'b0) begin fails++; $display("FAIL multi_clear got %b/%b exp 0/0", persist_fault_o, irq_o); end
    endtask

    task automatic test_clear();
        logic [8:0] pat [8];
        pat = '{9'h008, 9'h008, 9'h000, 9'h008, 9'h008, 9'h000, 9'h008, 9'h008};
        do_reset();
        for (int i = 0; i < 8; i++) errs(pat[i], 1);
        clear_i = 1; valid_i = 1; err_i = 9'h008; rd_req_i = 1; rd_idx_i = 4'd3;
        tick();
        clear_i = 0; valid_i = 0; err_i = '0; rd_req_i = 0;
        tests++; if (rd_ack_o !== 1'b1 || rd_data_o !== 8'd6) begin fails++; $display("FAIL clear_read got %b/%0d exp 1/6", rd_ack_o, rd_data_o); end
        tests++; if (sticky_o !== 9'h000 || irq_o !== 1'b0) begin fails++; $display("FAIL clear_sticky got %h/%b exp 000/0", sticky_o, irq_o); end
        tick();
        start_read(4'd3);
        tests++; if (rd_data_o !== 8'd0) begin fails++; $display("FAIL clear_cnt got %0d exp 0", rd_data_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        do_reset();
        errs(9'h1FF, 2);
        rd_req_i = 1; rd_idx_i = 4'd9;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_ack_o === 1'b1) begin
                acks++;
                tests++; if (rd_data_o !== 8'd0) begin fails++; $display("FAIL b2b_data%0d got %0d exp 0", i, rd_data_o); end
            end
        end
        rd_req_i = 0;
        tests++; if (acks !== 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", acks); end
        tick();
    endtask

    task automatic test_rst_ack();
        do_reset();
        errs(9'h002, 2);
        start_read(4'd1);
        tests++; if (rd_ack_o !== 1'b1 || rd_data_o !== 8'd2) begin fails++; $display("FAIL rstack_pre got %b/%0d exp 1/2", rd_ack_o, rd_data_o); end
        rst = 1; rd_req_i = 1; rd_idx_i = 4'd1;
        tick();
        rst = 0; rd_req_i = 0;
        tests++; if (rd_ack_o !== 1'b0 || rd_data_o !== 8'd0) begin fails++; $display("FAIL rstack_ack got %b/%0d exp 0/0", rd_ack_o, rd_data_o); end
        tests++; if (sticky_o !== 9'h000 || irq_o !== 1'b0 || persist_fault_o !== 1'b0 || fault_idx_o !== 4'd0)
            begin fails++; $display("FAIL rstack_outs got %h/%b/%b/%0d exp 000/0/0/0", sticky_o, irq_o, persist_fault_o, fault_idx_o); end
        tick();
        tests++; if (rd_ack_o !== 1'b0) begin fails++; $display("FAIL rstack_late got %b exp 0", rd_ack_o); end
        start_read(4'd1);
        tests++; if (rd_data_o !== 8'd0) begin fails++; $display("FAIL rstack_cnt got %0d exp 0", rd_data_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_count();
        test_saturate();
        test_persist();
        test_no_persist();
        test_multi();
        test_clear();
        test_back_to_back();
        test_rst_ack();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cv32e40p_tmr_err_monitor.md
CV32E40P_TMR_ERR_MONITOR -- requirements
Module: cv32e40p_tmr_err_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_SRC, 9, number of TMR voter error sources; matches the multiplier tmr_mult_err_o width.
- CNT_W, 8, width of each per-source saturating event counter.
- PERSIST_TH, 4, consecutive qualified error cycles that declare a persistent fault; legal range 2..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- err_i, in, NUM_SRC, voter mismatch flags from the multiplier TMR voters.
- valid_i, in, 1, qualifies err_i; driven from the multiplier enable.
- clear_i, in, 1, clears all error history.
- rd_req_i, in, 1, counter read request.
- rd_idx_i, in, 4, index of the source to read.
- rd_ack_o, out, 1, read data valid; one-cycle pulse.
- rd_data_o, out, CNT_W, counter value returned by the read.
- sticky_o, out, NUM_SRC, per-source sticky "error seen" flags.
- persist_fault_o, out, 1, a persistent fault has been latched.
- fault_idx_o, out, 4, source index of the latched persistent fault.
- irq_o, out, 1, level interrupt to the controller.

Function
REQ-003 A qualified error on source k SHALL be the condition valid_i=1 and err_i[k]=1 in the same cycle.
REQ-004 Counter k SHALL increment by 1 on each qualified error on source k.
REQ-005 Counter k SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-006 sticky_o[k] SHALL set on the cycle after the first qualified error on source k and hold until clear_i or rst.
REQ-007 Run counter k SHALL track consecutive qualified errors on source k:
- valid_i=1, err_i[k]=1: increment, saturating at PERSIST_TH.
- valid_i=1, err_i[k]=0: reset to 0.
- valid_i=0: hold.
REQ-008 The persistence FSM SHALL have two states, MON and FAULT, and SHALL reset to MON.
REQ-009 MON SHALL transition to FAULT when any run counter reaches PERSIST_TH.
REQ-010 On the MON-to-FAULT transition, fault_idx_o SHALL latch the lowest index among the sources reaching PERSIST_TH in that cycle.
REQ-011 FAULT SHALL hold fault_idx_o and return to MON only on clear_i or rst; later persistent sources SHALL NOT overwrite fault_idx_o.
REQ-012 persist_fault_o SHALL be 1 exactly when the FSM is in FAULT (registered, no combinational path from err_i).
REQ-013 irq_o SHALL equal the registered OR of all sticky_o bits and persist_fault_o.
REQ-014 The read FSM SHALL have two states, R_IDLE and R_ACK.
REQ-015 In R_IDLE with rd_req_i=1, the FSM SHALL capture counter[rd_idx_i] (value before any same-cycle update) and move to R_ACK.
REQ-016 R_ACK SHALL drive rd_ack_o=1 with the captured rd_data_o for exactly one cycle, then return to R_IDLE unconditionally.
REQ-017 rd_req_i held high continuously SHALL yield one read every 2 cycles.
REQ-018 rd_req_i SHALL be ignored while the read FSM is in R_ACK.
REQ-019 rd_idx_i >= NUM_SRC SHALL return rd_data_o=0 with a normal rd_ack_o pulse.
REQ-020 rd_data_o SHALL be 0 whenever rd_ack_o=0.
REQ-021 clear_i SHALL zero all counters, run counters and sticky flags, and force the persistence FSM to MON, on the next edge.
REQ-022 When clear_i coincides with a qualified error, clear SHALL win: no increment, no sticky set, no fault latch.
REQ-023 When clear_i coincides with a read capture, the read SHALL return the pre-clear value.
REQ-024 clear_i SHALL NOT affect the read FSM.
REQ-025 When errors on multiple sources occur in the same cycle, all affected counters SHALL update in that cycle.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL zero all counters, run counters and sticky_o, and set both FSMs to MON and R_IDLE.
REQ-027 Outputs after reset SHALL be: rd_ack_o=0, rd_data_o=0, persist_fault_o=0, fault_idx_o=0, irq_o=0.
REQ-028 rst SHALL take priority over clear_i, rd_req_i and all error inputs.
REQ-029 rst asserted while the read FSM is in R_ACK SHALL suppress that rd_ack_o pulse on the following cycle.

Verification
REQ-030 The bench SHALL cover these directed scenarios, one per line: stimulus -> required response.
- Error 3 cycles on source 4 with valid_i=1, then read idx 4 -> rd_ack_o one cycle later; rd_data_o=3; sticky_o=9'h010; irq_o=1; persist_fault_o=0.
- 300 qualified errors on source 0, then read idx 0 -> rd_data_o=255 (saturated, no wrap).
- err_i[2]=1 for 4 consecutive valid cycles with valid_i=0 gaps interleaved -> persist_fault_o=1, fault_idx_o=2.
- Same pattern but err_i[2]=0 on one valid cycle -> no fault.
- Sources 5 and 7 reach PERSIST_TH in the same cycle -> fault_idx_o=5; a later fault on source 1 -> fault_idx_o stays 5.
- clear_i in the same cycle as a qualified error on source 3 and a read of idx 3 holding 6 -> read returns 6; then counter 3=0, sticky_o=0, irq_o=0.
- rd_req_i held high for 6 cycles, idx 9 -> exactly 3 rd_ack_o pulses, each with rd_data_o=0.
- rst asserted during R_ACK -> rd_ack_o=0 next cycle; all outputs at reset values.
